scene_streamer: RTL
===================

# scene_streamer

Read-side front end of the scene buffer: accepts one ray per valid/ready handshake, then walks the scene BRAM from address 0 to NUM_OBJS-1. It presents one object per cycle to `ray_intersector`, together with that ray's origin and direction. It emits the single-cycle `ray_valid` trigger on exactly the cycle object 0 is presented, which is the alignment the intersector's object counters require. It sits between the ray generator/bounce logic and `ray_intersector`, and supports back-to-back rays with zero bubble cycles.

## Interface
Parameters:
- NUM_OBJS, default SCENE_BUFFER_DEPTH: objects streamed per ray; must be ≥1.
- READ_LATENCY, default SCENE_READ_LATENCY (2): BRAM cycles from address to data; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- ray_in_origin  in  fp24_vec3  ray origin to stream
- ray_in_dir  in  fp24_vec3  ray direction to stream
- ray_in_valid  in  1  request
- ray_in_ready  out  1  accept; a transfer occurs when valid && ready
- rd_addr  out  $clog2(NUM_OBJS)  scene BRAM read address (registered)
- rd_en  out  1  scene BRAM read enable
- rd_data  in  object  BRAM output, valid READ_LATENCY cycles after rd_addr/rd_en
- ray_origin  out  fp24_vec3  to intersector, aligned with obj
- ray_dir  out  fp24_vec3  to intersector, aligned with obj
- ray_valid  out  1  single-cycle pulse, coincident with object 0
- obj  out  object  current object; '0 when obj_valid is low
- obj_valid  out  1  high on every cycle an object is presented
- last_obj  out  1  high with object NUM_OBJS-1
- busy  out  1  reads issued but not all objects presented

## Operation
- Issue side has two states, IDLE and ISSUE. `rd_addr` is a counter.
- `ray_in_ready` = rst deasserted && (state==IDLE || rd_addr==NUM_OBJS-1).
- Handshake in cycle T:
  - latch ray_in_origin/dir into the issue register;
  - next cycle: state=ISSUE, rd_addr=0, rd_en=1.
- In ISSUE, rd_addr increments by 1 each cycle.
- At rd_addr==NUM_OBJS-1:
  - if a handshake occurs, the next cycle goes to rd_addr=0 and the new ray (no bubble);
  - otherwise the next cycle goes to IDLE with rd_en=0.
- Issue-side tags {rd_en, first=(rd_addr==0), last=(rd_addr==NUM_OBJS-1), ray origin/dir} are delayed READ_LATENCY cycles so they align with rd_data.
- Output stage is registered (one cycle):
  - obj_valid ← delayed rd_en
  - ray_valid ← delayed first && rd_en
  - last_obj ← delayed last && rd_en
  - obj ← rd_data when valid, else '0
  - ray_origin/ray_dir ← delayed ray
- ray_origin/ray_dir change only on a ray_valid cycle. They hold between rays.
- busy = rd_en || any delayed rd_en in flight || obj_valid.
- ray_in_valid dropping, or its data changing, while not ready is ignored. Data is sampled only at handshake.
- NUM_OBJS=1: ready stays high in ISSUE, and ray_valid, obj_valid and last_obj all assert on the same cycle.

## Timing
- Handshake at T → rd_addr=0 at T+1 → ray_valid and object 0 at T+2+READ_LATENCY → object k at T+2+READ_LATENCY+k → last_obj at T+1+READ_LATENCY+NUM_OBJS.
- Back-to-back: the next ray's ray_valid follows the previous last_obj on the very next cycle.
- Throughput: one ray per NUM_OBJS cycles.
- Reset (rst=0), effective immediately and asynchronously, regardless of in-flight state:
  - state=IDLE, rd_addr=0, rd_en=0, all tag pipelines 0;
  - ray_valid=0, obj_valid=0, last_obj=0, busy=0, ray_in_ready=0;
  - obj, ray_origin, ray_dir = '0.
- After rst rises, ray_in_ready=1 in the first cycle. Data in flight at reset is discarded. No partial stream resumes.

## Structure
- Shared package (existing rtx package): `object`, `fp24_vec3`, `material`, SCENE_BUFFER_DEPTH. Add SCENE_READ_LATENCY there; the BRAM wrapper uses it too.
- Reuse the existing `pipeline` module for the READ_LATENCY tag delay:
  - one instance, WIDTH = 3 + 2*$bits(fp24_vec3);
  - it has no reset, so gate its valid bits with a reset-cleared shift register of READ_LATENCY valid flags.
- No other sub-modules. Issue FSM and output stage are local.

## Test plan
All tests use NUM_OBJS=4, READ_LATENCY=2, with the BRAM model returning obj.mat = address+1.
- **Single ray.**
  - Stimulus: handshake at cycle 10.
  - Response: rd_addr 0..3 at cycles 11..14; ray_valid only at 14; obj.mat 1,2,3,4 at 14..17; last_obj at 17; ray_in_ready low 11..13, high 14 (issuing address 3); idle again from 15.
- **Back-to-back.**
  - Stimulus: ray A at cycle 10; ray B held valid from cycle 11.
  - Response: B accepted at 14; B's ray_valid at 18, directly after A's last_obj at 17; ray_origin switches from A to B exactly at 18.
- **Stall and ignore.**
  - Stimulus: ray_in_valid held with changing data while ready is low.
  - Response: only the value present on the handshake cycle appears on ray_origin.
- **Reset mid-stream.**
  - Stimulus: rst=0 at cycle 15 of the single-ray case.
  - Response: outputs are 0 before the next edge; after release, no obj_valid until a new handshake; a new ray streams all 4 objects from address 0.
- **NUM_OBJS=1 variant.**
  - Stimulus: ray_in_valid held high continuously.
  - Response: ray_valid, obj_valid and last_obj high every cycle from steady state; ray_origin advances each cycle.
- **End-to-end with ray_intersector.**
  - Stimulus: 4 spheres; the ray hits spheres 1 and 3; sphere 3 is nearer.
  - Response: hit_valid asserts once per ray with hit_mat of sphere 3.

Source files
------------

// File: rtl/rtx_pkg.sv
// Shared ray-tracer types: fixed-point vectors, scene objects and scene buffer sizing.
package rtx_pkg;

  localparam int unsigned FP24_W             = 24;
  localparam int unsigned MATERIAL_W         = 8;
  localparam int unsigned SCENE_BUFFER_DEPTH = 16;
  localparam int unsigned SCENE_READ_LATENCY = 2;

  typedef logic [FP24_W-1:0]     fp24;
  typedef logic [MATERIAL_W-1:0] material;

  typedef struct packed {
    fp24 x;
    fp24 y;
    fp24 z;
  } fp24_vec3;

  typedef struct packed {
    fp24_vec3 center;
    fp24      radius;
    material  mat;
  } object;

  // Issue-side sideband that travels alongside the scene BRAM read
  typedef struct packed {
    logic     en;
    logic     first;
    logic     last;
    fp24_vec3 origin;
    fp24_vec3 dir;
  } stream_tag_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } stream_state_t;

endpackage

// File: rtl/pipeline.sv
// Fixed-depth delay line with no reset; callers qualify the data with their own valid.
module pipeline #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    stage[0] <= d;
    for (int i = 1; i < DEPTH; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/scene_streamer.sv
// Streams every scene object once per accepted ray, aligned with that ray, towards the intersector.
module scene_streamer
  import rtx_pkg::*;
#(
  parameter  int unsigned NUM_OBJS     = SCENE_BUFFER_DEPTH,
  parameter  int unsigned READ_LATENCY = SCENE_READ_LATENCY,
  localparam int unsigned ADDR_W       = (NUM_OBJS > 1) ? $clog2(NUM_OBJS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  fp24_vec3          ray_in_origin,
  input  fp24_vec3          ray_in_dir,
  input  logic              ray_in_valid,
  output logic              ray_in_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  object             rd_data,
  output fp24_vec3          ray_origin,
  output fp24_vec3          ray_dir,
  output logic              ray_valid,
  output object             obj,
  output logic              obj_valid,
  output logic              last_obj,
  output logic              busy
);

  localparam int unsigned       TAG_W     = 3 + 2 * $bits(fp24_vec3);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_OBJS - 1);

  stream_state_t         state, state_nxt;
  logic [ADDR_W-1:0]     addr_nxt;
  logic                  rd_en_nxt;
  logic                  at_last;
  logic                  accept;
  fp24_vec3              iss_origin, iss_dir;
  stream_tag_t           tag_in, tag_out;
  logic [TAG_W-1:0]      tag_q;
  logic [READ_LATENCY-1:0] vld_sr;
  logic                  d_en;

  assign at_last      = (rd_addr == LAST_ADDR);
  assign ray_in_ready = rst && ((state == IDLE) || at_last);
  assign accept       = ray_in_valid && ray_in_ready;

  // Issue FSM: next address / state
  always_comb begin
    state_nxt = state;
    addr_nxt  = rd_addr;
    rd_en_nxt = rd_en;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ISSUE;
          addr_nxt  = '0;
          rd_en_nxt = 1'b1;
        end
      end
      ISSUE: begin
        if (at_last) begin
          addr_nxt = '0;
          if (accept) begin
            state_nxt = ISSUE;
            rd_en_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            rd_en_nxt = 1'b0;
          end
        end else begin
          addr_nxt = rd_addr + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
        rd_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      iss_origin <= '0;
      iss_dir    <= '0;
    end else begin
      state   <= state_nxt;
      rd_addr <= addr_nxt;
      rd_en   <= rd_en_nxt;
      if (accept) begin
        iss_origin <= ray_in_origin;
        iss_dir    <= ray_in_dir;
      end
    end
  end

  // Sideband delayed to line up with rd_data
  assign tag_in = '{en: rd_en, first: (rd_addr == '0), last: at_last,
                    origin: iss_origin, dir: iss_dir};

  pipeline #(
    .WIDTH(TAG_W),
    .DEPTH(READ_LATENCY)
  ) u_tag_pipe (
    .clk (clk),
    .d   (TAG_W'(tag_in)),
    .q   (tag_q)
  );

  assign tag_out = stream_tag_t'(tag_q);

  // The tag delay line holds stale data after reset; this resettable flag chain qualifies it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_sr <= '0;
    else      vld_sr <= READ_LATENCY'({vld_sr, rd_en});
  end

  assign d_en = vld_sr[READ_LATENCY-1] && tag_out.en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      obj_valid  <= 1'b0;
      ray_valid  <= 1'b0;
      last_obj   <= 1'b0;
      obj        <= '0;
      ray_origin <= '0;
      ray_dir    <= '0;
    end else begin
      obj_valid <= d_en;
      ray_valid <= d_en && tag_out.first;
      last_obj  <= d_en && tag_out.last;
      obj       <= d_en ? rd_data : '0;
      if (d_en && tag_out.first) begin
        ray_origin <= tag_out.origin;
        ray_dir    <= tag_out.dir;
      end
    end
  end

  assign busy = rd_en || (|vld_sr) || obj_valid;

endmodule
